// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA/DVI raster timing generator. A divider turns the system
// clock into a one-clk-wide pixel clock-enable. Horizontal and vertical
// counters advance on that enable. Combinational decode of the counters
// produces sync, DE, coordinates, blanking and line/frame strobes. A short
// shift register delivers copies of sync/DE delayed by PIPE_DLY pixels, so
// they line up with downstream RGB pipelines.
//
// Ports:
//   clk          system clock, single domain
//   reset        synchronous active-high reset
//   en           run enable; low freezes divider, counters and delay line
//   pix_ce       pixel clock-enable, high for one clk every CLK_DIV clks
//   h_sync       horizontal sync, asserted level HS_POL
//   v_sync       vertical sync, asserted level VS_POL
//   DE           display enable, high inside the active area
//   x_pixel      raw horizontal counter
//   y_pixel      raw vertical counter
//   line_start   pulse on the pix_ce of pixel 0 of every line
//   frame_start  pulse on the pix_ce of pixel (0,0)
//   vblank       high while the vertical counter is outside the active lines
//   h_sync_d     h_sync delayed PIPE_DLY pixels
//   v_sync_d     v_sync delayed PIPE_DLY pixels
//   DE_d         DE delayed PIPE_DLY pixels
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_DLY = 2,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_ce,
  output logic             h_sync,
  output logic             v_sync,
  output logic             DE,
  output logic [CNT_W-1:0] x_pixel,
  output logic [CNT_W-1:0] y_pixel,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank,
  output logic             h_sync_d,
  output logic             v_sync_d,
  output logic             DE_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Refuse to elaborate with totals that do not fit the counters.
  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Decode boundaries are one bit wider than the counters, because a
  // boundary such as the sync end can equal 2^CNT_W when the back porch
  // is zero.
  localparam logic [CNT_W:0] H_ACT_END  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SYNC_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_END  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SYNC_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [CNT_W:0]   h_ext, v_ext;

  // With CLK_DIV=1 the divider register is stuck at 0, so this reduces to en.
  assign pix_ce = en && (div_q == DIV_LAST);

  // Next-state logic. The divider runs whenever en is high. The raster
  // counters move only on pix_ce. The vertical counter steps on the same
  // edge where the horizontal counter wraps.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  // Counter registers. Reset wins over en, so a pulse anywhere in the
  // frame restarts the raster from pixel (0,0) with a fresh divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  assign h_sync      = (h_ext >= H_SYNC_BEG && h_ext < H_SYNC_END) ? HS_ON : ~HS_ON;
  assign v_sync      = (v_ext >= V_SYNC_BEG && v_ext < V_SYNC_END) ? VS_ON : ~VS_ON;
  assign DE          = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign vblank      = (v_ext >= V_ACT_END);
  assign x_pixel     = h_q;
  assign y_pixel     = v_q;
  assign line_start  = pix_ce && (h_q == '0);
  assign frame_start = line_start && (v_q == '0);

  if (PIPE_DLY == 0) begin : g_no_dly
    assign h_sync_d = h_sync;
    assign v_sync_d = v_sync;
    assign DE_d     = DE;
  end else begin : g_dly
    // Each stage holds {h_sync, v_sync, DE}.
    logic [2:0] pipe_q [PIPE_DLY];

    // Shift register for the delayed sync/DE copies. It advances once per
    // pixel, so the delay is counted in pixels rather than clks. It holds
    // while en is low because pix_ce is then low.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          pipe_q[i] <= {~HS_ON, ~VS_ON, 1'b0};
        end
      end else if (pix_ce) begin
        pipe_q[0] <= {h_sync, v_sync, DE};
        for (int i = 1; i < PIPE_DLY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign {h_sync_d, v_sync_d, DE_d} = pipe_q[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share clk/reset/en:
//   inst0  default 640x480 timing, CLK_DIV=4, PIPE_DLY=2, active-low syncs
//   inst1  tiny raster (15x13 totals), CLK_DIV=3, PIPE_DLY=3, HS_POL=1
//   inst2  tiny raster with H_TOTAL = 2^CNT_W, CLK_DIV=1, PIPE_DLY=0,
//          both syncs active-high
// The reference model counts the enabled clks since the last reset. From
// that count it derives the pixel index, the coordinates and every output
// with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Packed observation: {pix_ce, h_sync, v_sync, DE, line_start,
  // frame_start, vblank, h_sync_d, v_sync_d, DE_d, x[15:0], y[15:0]}
  typedef logic [41:0] obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;

  longint n = 0;
  int compared   = 0;
  int mismatched = 0;

  obs_t obsAct [3];
  obs_t expv   [3];

  logic aPixCe, aHs, aVs, aDe, aLs, aFs, aVb, aHsD, aVsD, aDeD;
  logic [9:0] aX, aY;
  logic bPixCe, bHs, bVs, bDe, bLs, bFs, bVb, bHsD, bVsD, bDeD;
  logic [3:0] bX, bY;
  logic cPixCe, cHs, cVs, cDe, cLs, cFs, cVb, cHsD, cVsD, cDeD;
  logic [3:0] cX, cY;

  always #5 clk = ~clk;

  vga_timing_gen dutA (
    .clk(clk), .reset(reset), .en(en),
    .pix_ce(aPixCe), .h_sync(aHs), .v_sync(aVs), .DE(aDe),
    .x_pixel(aX), .y_pixel(aY), .line_start(aLs), .frame_start(aFs),
    .vblank(aVb), .h_sync_d(aHsD), .v_sync_d(aVsD), .DE_d(aDeD)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(3), .HS_POL(1), .VS_POL(0), .PIPE_DLY(3), .CNT_W(4)
  ) dutB (
    .clk(clk), .reset(reset), .en(en),
    .pix_ce(bPixCe), .h_sync(bHs), .v_sync(bVs), .DE(bDe),
    .x_pixel(bX), .y_pixel(bY), .line_start(bLs), .frame_start(bFs),
    .vblank(bVb), .h_sync_d(bHsD), .v_sync_d(bVsD), .DE_d(bDeD)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(1), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1), .VS_POL(1), .PIPE_DLY(0), .CNT_W(4)
  ) dutC (
    .clk(clk), .reset(reset), .en(en),
    .pix_ce(cPixCe), .h_sync(cHs), .v_sync(cVs), .DE(cDe),
    .x_pixel(cX), .y_pixel(cY), .line_start(cLs), .frame_start(cFs),
    .vblank(cVb), .h_sync_d(cHsD), .v_sync_d(cVsD), .DE_d(cDeD)
  );

  always_comb begin
    obsAct[0] = {aPixCe, aHs, aVs, aDe, aLs, aFs, aVb, aHsD, aVsD, aDeD, 16'(aX), 16'(aY)};
    obsAct[1] = {bPixCe, bHs, bVs, bDe, bLs, bFs, bVb, bHsD, bVsD, bDeD, 16'(bX), 16'(bY)};
    obsAct[2] = {cPixCe, cHs, cVs, cDe, cLs, cFs, cVb, cHsD, cVsD, cDeD, 16'(cX), 16'(cY)};
  end

  // Expected outputs after `cnt` enabled clks since reset, with the enable
  // currently at `enNow`.
  function automatic obs_t model(input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int d, input int hp, input int vp, input int pd,
                                 input longint cnt, input bit enNow);
    int ht, vt, h, v, hd, vdl;
    longint p;
    bit ce, hsy, vsy, de, ls, fs, blank, hsd, vsd, ded, hOn, vOn;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    hOn = (hp != 0);
    vOn = (vp != 0);
    p   = cnt / d;
    h   = int'(p % ht);
    v   = int'((p / ht) % vt);
    ce  = enNow && ((cnt % d) == longint'(d - 1));
    hsy = (h >= ha + hf && h < ha + hf + hs) ? hOn : !hOn;
    vsy = (v >= va + vf && v < va + vf + vs) ? vOn : !vOn;
    de  = (h < ha) && (v < va);
    blank = (v >= va);
    ls  = ce && (h == 0);
    fs  = ls && (v == 0);
    if (pd == 0) begin
      hsd = hsy; vsd = vsy; ded = de;
    end else if (p < pd) begin
      hsd = !hOn; vsd = !vOn; ded = 1'b0;
    end else begin
      hd  = int'((p - pd) % ht);
      vdl = int'(((p - pd) / ht) % vt);
      hsd = (hd >= ha + hf && hd < ha + hf + hs) ? hOn : !hOn;
      vsd = (vdl >= va + vf && vdl < va + vf + vs) ? vOn : !vOn;
      ded = (hd < ha) && (vdl < va);
    end
    return {ce, hsy, vsy, de, ls, fs, blank, hsd, vsd, ded, 16'(h), 16'(v)};
  endfunction

  // Advance one clk, update the enabled-clk count, then compute expectations
  // just after the edge.
  task automatic step();
    @(posedge clk);
    if (reset) n = 0;
    else if (en) n++;
    #1;
    expv[0] = model(640, 16, 96, 48, 480, 10, 2, 33, 4, 0, 0, 2, n, en);
    expv[1] = model(8, 2, 3, 2, 6, 2, 2, 3, 3, 1, 0, 3, n, en);
    expv[2] = model(10, 1, 3, 2, 5, 1, 2, 1, 1, 1, 1, 0, n, en);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_reset inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
      compared++;
      if ({aX, aY, aDe, aHs, aVs, aPixCe, aLs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL reset_state: got x=%0d y=%0d de=%b hs=%b vs=%b ce=%b ls=%b expected 0/0/1/1/1/0/0",
                 aX, aY, aDe, aHs, aVs, aPixCe, aLs);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_reset inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
      // The fourth clk period after release carries the first pix_ce, and
      // x becomes 1 one clk later.
      compared++;
      if (aPixCe !== (c == 3) || aX !== ((c >= 4) ? 10'd1 : 10'd0)) begin
        mismatched++;
        $display("[TB] FAIL first_pix_ce c=%0d: got ce=%b x=%0d expected ce=%b x=%0d",
                 c, aPixCe, aX, (c == 3), (c >= 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_line();
    int hsLow, deHigh, lsCount;
    hsLow = 0; deHigh = 0; lsCount = 0;
    reset = 1'b1;
    en    = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3200; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_line inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
      if (aPixCe && !aHs) hsLow++;
      if (aPixCe && aDe) deHigh++;
      if (aLs) lsCount++;
    end
    compared++;
    if (hsLow !== 96 || deHigh !== 640 || lsCount !== 1) begin
      mismatched++;
      $display("[TB] FAIL line_counts: got hsLow=%0d deHigh=%0d ls=%0d expected 96/640/1", hsLow, deHigh, lsCount);
    end
    compared++;
    if (aX !== 10'd0 || aY !== 10'd1) begin
      mismatched++;
      $display("[TB] FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", aX, aY);
    end
  endtask

  task automatic test_frame();
    int bFrames, cFrames, cCe;
    bFrames = 0; cFrames = 0; cCe = 0;
    reset = 1'b1;
    en    = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 1170; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_frame inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
      if (bFs) bFrames++;
      if (cFs) cFrames++;
      if (cPixCe) cCe++;
    end
    // inst1 frame = 15*13*3 = 585 clks; inst2 frame = 16*9 = 144 clks.
    compared++;
    if (bFrames !== 2 || cFrames !== 8 || cCe !== 1170) begin
      mismatched++;
      $display("[TB] FAIL frame_counts: got b=%0d c=%0d cCe=%0d expected 2/8/1170", bFrames, cFrames, cCe);
    end
  endtask

  task automatic test_enable();
    reset = 1'b1;
    en    = 1'b1;
    step();
    reset = 1'b0;
    // Reach pixel (100,5) of inst0 plus two clks into the next divider period.
    for (int c = 0; c < 16402; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_enable inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
    end
    en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_enable_hold inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
      compared++;
      if (aPixCe !== 1'b0 || aX !== 10'd100 || aY !== 10'd5) begin
        mismatched++;
        $display("[TB] FAIL freeze: got ce=%b x=%0d y=%0d expected 0/100/5", aPixCe, aX, aY);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      step();
      compared++;
      if (aX !== ((c == 2) ? 10'd101 : 10'd100) || aPixCe !== (c == 1)) begin
        mismatched++;
        $display("[TB] FAIL resume c=%0d: got x=%0d ce=%b expected x=%0d ce=%b",
                 c, aX, aPixCe, (c == 2) ? 101 : 100, (c == 1));
      end
    end
    for (int c = 0; c < 2000; c++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_enable_rand inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    int runLen;
    en     = 1'b1;
    runLen = $urandom_range(10, 500);
    for (int c = 0; c < runLen; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (obsAct[k] !== expv[k]) begin
        mismatched++;
        $display("[TB] FAIL test_reset_midline inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
      end
    end
    compared++;
    if ({aX, aY, bX, bY, cX, cY} !== 36'd0) begin
      mismatched++;
      $display("[TB] FAIL midline_reset: got a=%0d/%0d b=%0d/%0d c=%0d/%0d expected all 0",
               aX, aY, bX, bY, cX, cY);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obsAct[k] !== expv[k]) begin
          mismatched++;
          $display("[TB] FAIL test_back_to_back inst%0d n=%0d: got %h expected %h", k, n, obsAct[k], expv[k]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] starting vga_timing_gen checks");
    test_reset();
    test_line();
    test_frame();
    test_enable();
    test_reset_midline();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/DVI timing generator and successor to the fixed 640x480 controller. It derives a pixel clock-enable from the system clock and runs horizontal and vertical counters over fully parametrised porch, sync and active widths. It produces sync signals with selectable polarity, DE, pixel coordinates and line/frame strobes. It also provides copies of sync and DE delayed by a configurable number of pixels, so they stay aligned with downstream RGB pipelines (e.g. the braille glyph renderer).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1)
HS_POL, 0, asserted level of h_sync (0 = active-low)
VS_POL, 0, asserted level of v_sync
PIPE_DLY, 2, pixel delay applied to the *_d outputs (>=0)
CNT_W, 10, width of counters and coordinates

Ports:
clk        in   1      system clock, single clock domain
reset      in   1      synchronous, active-high reset
en         in   1      run enable; low freezes timing
pix_ce     out  1      pixel clock-enable, one clk wide
h_sync     out  1      horizontal sync, polarity HS_POL
v_sync     out  1      vertical sync, polarity VS_POL
DE         out  1      display enable (active area)
x_pixel    out  CNT_W  horizontal counter value
y_pixel    out  CNT_W  vertical counter value
line_start out  1      one-clk pulse at pixel (0, any line)
frame_start out 1      one-clk pulse at pixel (0,0)
vblank     out  1      high while v_counter >= V_ACTIVE
h_sync_d   out  1      h_sync delayed PIPE_DLY pixels
v_sync_d   out  1      v_sync delayed PIPE_DLY pixels
DE_d       out  1      DE delayed PIPE_DLY pixels

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Elaboration fails if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if CLK_DIV < 1.
- Reset (sampled on posedge clk only): div counter, h_counter and v_counter go to 0. Delay-line stages go to sync inactive (!HS_POL / !VS_POL) and DE 0. Reset overrides en at any point in a frame.
- Divider: div counts 0..CLK_DIV-1 while en=1. pix_ce = en && (div == CLK_DIV-1), combinational. CLK_DIV=1 gives pix_ce = en.
- Counters update only on clk edges where pix_ce=1:
  - h_counter wraps H_TOTAL-1 -> 0; otherwise increments.
  - v_counter increments only when h_counter == H_TOTAL-1, and wraps V_TOTAL-1 -> 0 on that same edge.
- en=0: div, h_counter, v_counter and the delay lines all hold, and pix_ce=0. On en reasserting, the divider resumes from its held value. There is no restart.
- Decode is combinational from the counters:
  - h_sync = HS_POL when H_ACTIVE+H_FP <= h_counter < H_ACTIVE+H_FP+H_SYNC, else !HS_POL. v_sync is analogous with VS_POL.
  - DE = (h_counter < H_ACTIVE) && (v_counter < V_ACTIVE).
  - x_pixel = h_counter and y_pixel = v_counter (raw, not blanked).
  - vblank = v_counter >= V_ACTIVE.
  - line_start = pix_ce && h_counter==0.
  - frame_start = line_start && v_counter==0.
- Reset values follow from the counters at 0: h_sync=!HS_POL, v_sync=!VS_POL, DE=1, x/y=0, vblank=0, pix_ce=0 (1 if CLK_DIV=1 and en=1), line_start/frame_start=0 until the first pix_ce.
- Delay line: a PIPE_DLY-deep shift register holding {h_sync, v_sync, DE}, shifted only on pix_ce. The *_d outputs are the last stage. PIPE_DLY=0 makes *_d equal the undelayed signals combinationally.
- Latency:
  - the first pix_ce after reset release falls in clk cycle CLK_DIV;
  - x_pixel first reaches 1 in cycle CLK_DIV+1;
  - one full frame is H_TOTAL*V_TOTAL*CLK_DIV clks.

Test Plan:
1. Defaults, reset held 3 clks then released, en=1 -> pix_ce high every 4th clk (cycles 4, 8, ...); x_pixel, y_pixel, DE, h_sync and v_sync hold 0/0/1/1/1 until the first update.
2. Defaults, run one line -> DE falls when x_pixel=640; h_sync=0 exactly for x_pixel 656..751; line_start pulses when x_pixel=0; x wraps 799->0 and y goes 0->1 on the same edge.
3. Defaults, run a full frame -> v_sync=0 only for y 490..491; vblank=1 for y 480..524; y wraps 524->0; frame_start pulses once per 420000 pix_ce (1,680,000 clks).
4. PIPE_DLY=2 -> DE_d falls exactly 2 pix_ce after DE falls at x=640; h_sync_d is low for x 658..753. With PIPE_DLY=0, *_d equals the undelayed outputs every cycle.
5. en dropped at x=100, y=5 for 50 clks -> counters, div and *_d frozen and pix_ce=0 throughout; on en reasserting, the next pix_ce arrives after the remaining divider count and x resumes at 101. A reset pulse applied mid-line, with en=1, returns all counters to 0 on the next edge.
6. Alternate mode: CLK_DIV=1, 800x600@60 (H 800/40/128/88, V 600/1/4/23, HS_POL=1, VS_POL=1, CNT_W=11) -> pix_ce constant high; h_sync=1 for x 840..967; v_sync=1 for y 601..604; frame period 1056*628 clks.
